// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_arb_pkg
// Brief   : Shared types and default constants for the SPI bus arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_XFER   = 3'd3,
        ST_GUARD  = 3'd4
    } arb_state_t;

    localparam int C_DEF_NREQ    = 4;
    localparam int C_DEF_SETUP   = 2;
    localparam int C_DEF_GUARD   = 2;
    localparam int C_DEF_TIMEOUT = 255;
    localparam int C_CNT_W       = 8;
    localparam int C_ID_W        = 3;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; search starts at last+1.
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NREQ = C_DEF_NREQ
) (
    input  logic [NREQ-1:0]   req,
    input  logic [C_ID_W-1:0] last,
    output logic [NREQ-1:0]   onehot,
    output logic [C_ID_W-1:0] idx,
    output logic              any
);

    int w_dist;
    int w_best;

    // Distance of each candidate from last+1 (mod NREQ); nearest requester wins.
    always_comb begin
        idx    = '0;
        w_dist = 0;
        w_best = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = j - int'(last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = C_ID_W'(j);
            end
        end
    end

    assign any = |req;

    always_comb begin
        onehot = '0;
        for (int j = 0; j < NREQ; j++) begin
            onehot[j] = any && (idx == C_ID_W'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_bus_arbiter
// Brief   : Round-robin sharing of one SPI byte engine and its slave select.
// Rev     : 1.0  initial release
// ============================================================================
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = C_DEF_NREQ,
    parameter int SETUP   = C_DEF_SETUP,
    parameter int GUARD   = C_DEF_GUARD,
    parameter int TIMEOUT = C_DEF_TIMEOUT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic [NREQ-1:0]      byte_valid_i,
    input  logic [8*NREQ-1:0]    byte_data_i,
    output logic [NREQ-1:0]      byte_ready_o,
    output logic [NREQ-1:0]      rx_valid_o,
    output logic [7:0]           rx_data_o,
    output logic                 eng_start_o,
    output logic [7:0]           eng_tx_o,
    input  logic                 eng_done_i,
    input  logic [7:0]           eng_rx_i,
    output logic                 spi_ss_o,
    output logic                 timeout_o,
    output logic [2:0]           timeout_id_o
);

    localparam logic [C_CNT_W-1:0] C_SETUP_CNT   = C_CNT_W'(SETUP);
    localparam logic [C_CNT_W-1:0] C_GUARD_CNT   = C_CNT_W'(GUARD);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT_CNT = C_CNT_W'(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_ONE         = C_CNT_W'(1);

    arb_state_t          r_state,      w_state_nxt;
    logic [NREQ-1:0]     r_gnt,        w_gnt_nxt;
    logic                r_ss,         w_ss_nxt;
    logic [C_CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic [C_ID_W-1:0]   r_last,       w_last_nxt;
    logic                r_start,      w_start_nxt;
    logic [7:0]          r_tx,         w_tx_nxt;
    logic [NREQ-1:0]     r_rx_valid,   w_rx_valid_nxt;
    logic [7:0]          r_rx_data,    w_rx_data_nxt;
    logic                r_timeout,    w_timeout_nxt;
    logic [2:0]          r_timeout_id, w_timeout_id_nxt;

    logic [NREQ-1:0]     w_pick_oh;
    logic [C_ID_W-1:0]   w_pick_idx;
    logic                w_pick_any;
    logic                w_own_valid;
    logic                w_own_req;
    logic [7:0]          w_own_data;
    logic [C_CNT_W-1:0]  w_cnt_inc;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_pick (
        .req    (req_i),
        .last   (r_last),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    // The registered one-hot grant doubles as the owner select.
    assign w_own_valid = |(byte_valid_i & r_gnt);
    assign w_own_req   = |(req_i & r_gnt);
    assign w_cnt_inc   = r_cnt + C_ONE;

    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_own_data = byte_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_ss_nxt         = r_ss;
        w_cnt_nxt        = r_cnt;
        w_last_nxt       = r_last;
        w_start_nxt      = 1'b0;
        w_tx_nxt         = r_tx;
        w_rx_valid_nxt   = '0;
        w_rx_data_nxt    = r_rx_data;
        w_timeout_nxt    = 1'b0;
        w_timeout_id_nxt = r_timeout_id;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_oh;
                    w_ss_nxt    = 1'b0;
                    w_cnt_nxt   = C_SETUP_CNT;
                    w_last_nxt  = w_pick_idx;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt <= C_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_ACTIVE: begin
                // Handshake outranks both a dropped request and an expiring watchdog.
                if (w_own_valid) begin
                    w_tx_nxt    = w_own_data;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_XFER;
                end else if (!w_own_req || (w_cnt_inc == C_TIMEOUT_CNT)) begin
                    if (w_own_req) begin
                        w_timeout_nxt    = 1'b1;
                        w_timeout_id_nxt = 3'(r_last);
                    end
                    w_gnt_nxt   = '0;
                    w_ss_nxt    = 1'b1;
                    w_cnt_nxt   = C_GUARD_CNT;
                    w_state_nxt = ST_GUARD;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_XFER: begin
                if (eng_done_i) begin
                    w_rx_data_nxt  = eng_rx_i;
                    w_rx_valid_nxt = r_gnt;
                    w_state_nxt    = ST_ACTIVE;
                end
            end
            ST_GUARD: begin
                if (r_cnt <= C_ONE) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_ss         <= 1'b1;
            r_cnt        <= '0;
            r_last       <= C_ID_W'(NREQ - 1);
            r_start      <= 1'b0;
            r_tx         <= '0;
            r_rx_valid   <= '0;
            r_rx_data    <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ss         <= w_ss_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last       <= w_last_nxt;
            r_start      <= w_start_nxt;
            r_tx         <= w_tx_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timeout_id <= w_timeout_id_nxt;
        end
    end

    assign gnt_o        = r_gnt;
    assign spi_ss_o     = r_ss;
    assign byte_ready_o = (r_state == ST_ACTIVE) ? r_gnt : '0;
    assign eng_start_o  = r_start;
    assign eng_tx_o     = r_tx;
    assign rx_valid_o   = r_rx_valid;
    assign rx_data_o    = r_rx_data;
    assign timeout_o    = r_timeout;
    assign timeout_id_o = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_bus_arbiter
// Brief   : Self-checking bench for spi_bus_arbiter with a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int NREQ    = 4;
    localparam int SETUP   = 2;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 255;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_ni;
    logic [NREQ-1:0]     req_i;
    logic [NREQ-1:0]     gnt_o;
    logic [NREQ-1:0]     byte_valid_i;
    logic [8*NREQ-1:0]   byte_data_i;
    logic [NREQ-1:0]     byte_ready_o;
    logic [NREQ-1:0]     rx_valid_o;
    logic [7:0]          rx_data_o;
    logic                eng_start_o;
    logic [7:0]          eng_tx_o;
    logic                eng_done_i;
    logic [7:0]          eng_rx_i;
    logic                spi_ss_o;
    logic                timeout_o;
    logic [2:0]          timeout_id_o;

    spi_bus_arbiter #(
        .NREQ         (NREQ),
        .SETUP        (SETUP),
        .GUARD        (GUARD),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_ni    (wb_rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .eng_start_o  (eng_start_o),
        .eng_tx_o     (eng_tx_o),
        .eng_done_i   (eng_done_i),
        .eng_rx_i     (eng_rx_i),
        .spi_ss_o     (spi_ss_o),
        .timeout_o    (timeout_o),
        .timeout_id_o (timeout_id_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         m_last   = NREQ - 1;
    bit         eng_busy = 1'b0;
    int         eng_cnt  = 0;
    int         eng_lat  = 8;
    int         done_cyc = -1;
    logic [7:0] eng_tx_lat = '0;
    logic [7:0] data_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester found scanning from last+1 mod NREQ.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
        end
        return -1;
    endfunction

    // One clock: outputs are sampled on the falling edge, engine model echoes ~tx.
    task automatic tick();
        @(negedge wb_clk_i);
        cyc++;
        eng_done_i = 1'b0;
        if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_done_i = 1'b1;
                eng_rx_i   = ~eng_tx_lat;
                eng_busy   = 1'b0;
                done_cyc   = cyc;
                chk("eng_tx_stable", 32'(eng_tx_o), 32'(eng_tx_lat));
            end else begin
                eng_cnt--;
            end
        end
        if (eng_start_o) begin
            eng_busy   = 1'b1;
            eng_tx_lat = eng_tx_o;
            eng_cnt    = eng_lat;
        end
    endtask

    task automatic check_reset();
        chk("rst_gnt", 32'(gnt_o), 32'(0));
        chk("rst_ss", 32'(spi_ss_o), 32'(1));
        chk("rst_ready", 32'(byte_ready_o), 32'(0));
        chk("rst_start", 32'(eng_start_o), 32'(0));
        chk("rst_tx", 32'(eng_tx_o), 32'(0));
        chk("rst_rx_valid", 32'(rx_valid_o), 32'(0));
        chk("rst_rx_data", 32'(rx_data_o), 32'(0));
        chk("rst_timeout", 32'(timeout_o), 32'(0));
        chk("rst_timeout_id", 32'(timeout_id_o), 32'(0));
    endtask

    task automatic open_frame(input logic [NREQ-1:0] reqs, output int k, output logic [NREQ-1:0] oh);
        k  = pick(reqs);
        oh = '0;
        if (k >= 0) begin
            oh[k]  = 1'b1;
            m_last = k;
        end
        req_i = reqs;
        tick();
        chk("grant", 32'(gnt_o), 32'(oh));
        chk("ss_low", 32'(spi_ss_o), 32'(0));
        for (int j = 1; j <= SETUP; j++) begin
            tick();
            chk("ready_setup", 32'(byte_ready_o), (j == SETUP) ? 32'(oh) : 32'(0));
        end
    endtask

    task automatic send_byte(input int k, input logic [NREQ-1:0] oh, input int gap,
                             input bit drop_same, output logic [7:0] d);
        for (int g = 0; g < gap; g++) begin
            byte_valid_i = NREQ'($urandom) & ~oh;
            tick();
            chk("ready_idle", 32'(byte_ready_o), 32'(oh));
            chk("no_timeout", 32'(timeout_o), 32'(0));
            chk("rx_pulse_end", 32'(rx_valid_o), 32'(0));
        end
        d = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
        byte_data_i = $urandom;
        byte_data_i[8*k +: 8] = d;
        byte_valid_i = oh | NREQ'($urandom);
        if (drop_same) req_i[k] = 1'b0;
        tick();
        chk("eng_start", 32'(eng_start_o), 32'(1));
        chk("eng_tx", 32'(eng_tx_o), 32'(d));
        chk("hs_beats_timeout", 32'(timeout_o), 32'(0));
        chk("ready_xfer", 32'(byte_ready_o), 32'(0));
        byte_valid_i = '0;
    endtask

    task automatic finish_byte(input int k, input logic [NREQ-1:0] oh, input logic [7:0] d, input bit drop_now);
        int         n;
        logic [7:0] nd;
        if (drop_now) req_i[k] = 1'b0;
        tick();
        chk("start_once", 32'(eng_start_o), 32'(0));
        n = 0;
        while (rx_valid_o == '0 && n < 64) begin
            tick();
            n++;
        end
        nd = ~d;
        chk("rx_valid", 32'(rx_valid_o), 32'(oh));
        chk("rx_data", 32'(rx_data_o), 32'(nd));
        chk("rx_latency", 32'(cyc), 32'(done_cyc + 1));
        chk("ready_back", 32'(byte_ready_o), 32'(oh));
        chk("gnt_held", 32'(gnt_o), 32'(oh));
    endtask

    task automatic close_frame(input int k, input logic [NREQ-1:0] req_after);
        req_i[k] = 1'b0;
        tick();
        chk("rel_gnt", 32'(gnt_o), 32'(0));
        chk("rel_ss", 32'(spi_ss_o), 32'(1));
        chk("rel_ready", 32'(byte_ready_o), 32'(0));
        chk("rel_rx_pulse", 32'(rx_valid_o), 32'(0));
        req_i = req_after;
        for (int j = 1; j <= GUARD; j++) begin
            tick();
            chk("guard_ss", 32'(spi_ss_o), 32'(1));
            chk("guard_gnt", 32'(gnt_o), 32'(0));
        end
    endtask

    // drop_mode: 0 drop after last RX, 1 drop during last XFER, 2 drop with last valid.
    task automatic frame(input logic [NREQ-1:0] reqs, input int nbytes, input int gap,
                         input int drop_mode, input logic [NREQ-1:0] req_after);
        int              k;
        logic [NREQ-1:0] oh;
        logic [7:0]      d;
        bit              lst;
        open_frame(reqs, k, oh);
        for (int b = 0; b < nbytes; b++) begin
            lst = (b == nbytes - 1);
            send_byte(k, oh, gap, lst && (drop_mode == 2), d);
            finish_byte(k, oh, d, lst && (drop_mode == 1));
        end
        close_frame(k, req_after);
    endtask

    task automatic timeout_frame(input logic [NREQ-1:0] reqs);
        int              k;
        logic [NREQ-1:0] oh;
        open_frame(reqs, k, oh);
        for (int j = 1; j < TIMEOUT; j++) begin
            byte_valid_i = NREQ'($urandom) & ~oh;
            tick();
            chk("to_ready", 32'(byte_ready_o), 32'(oh));
        end
        tick();
        chk("to_pulse", 32'(timeout_o), 32'(1));
        chk("to_id", 32'(timeout_id_o), 32'(k));
        chk("to_gnt", 32'(gnt_o), 32'(0));
        chk("to_ss", 32'(spi_ss_o), 32'(1));
        req_i        = '0;
        byte_valid_i = '0;
        tick();
        chk("to_pulse_end", 32'(timeout_o), 32'(0));
        chk("to_id_hold", 32'(timeout_id_o), 32'(k));
        for (int j = 2; j <= GUARD; j++) tick();
    endtask

    initial begin
        int              k;
        logic [NREQ-1:0] oh;
        logic [7:0]      d;
        logic [NREQ-1:0] reqs;

        wb_rst_ni    = 1'b0;
        req_i        = '0;
        byte_valid_i = '0;
        byte_data_i  = '0;
        eng_done_i   = 1'b0;
        eng_rx_i     = '0;
        tick();
        tick();
        check_reset();
        wb_rst_ni = 1'b1;

        // Single three-byte frame with fixed data
        eng_lat = 8;
        data_q  = '{8'hA5, 8'h3C, 8'hFF};
        frame(4'b0001, 3, 0, 0, '0);

        // Round-robin with 1011 re-raised during each guard
        for (int f = 0; f < 4; f++) frame(4'b1011, 1, 1, 0, 4'b1011);

        // Watchdog, then a handshake landing on the would-be timeout cycle
        timeout_frame(4'b0100);
        frame(4'b0100, 1, TIMEOUT - 1, 0, '0);
        chk("tid_held", 32'(timeout_id_o), 32'(2));

        // Request drop during XFER and together with valid
        frame(4'b0010, 2, 1, 1, '0);
        frame(4'b0010, 1, 0, 2, '0);

        // Stray engine completion while idle
        eng_done_i = 1'b1;
        eng_rx_i   = 8'h77;
        tick();
        chk("stray_rx_valid", 32'(rx_valid_o), 32'(0));
        chk("stray_gnt", 32'(gnt_o), 32'(0));

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            do reqs = NREQ'($urandom); while (reqs == '0);
            eng_lat = $urandom_range(1, 10);
            frame(reqs, $urandom_range(1, 3), $urandom_range(0, 4),
                  $urandom_range(0, 2), NREQ'($urandom));
        end

        // Reset while a byte is in flight
        eng_lat = 8;
        open_frame(4'b1000, k, oh);
        send_byte(k, oh, 0, 1'b0, d);
        tick();
        wb_rst_ni = 1'b0;
        tick();
        check_reset();
        eng_busy   = 1'b0;
        m_last     = NREQ - 1;
        wb_rst_ni  = 1'b1;
        req_i      = '0;
        frame(4'b1011, 1, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
